csa_tree_pipelined: RTL and testbench

//  Parametrised, pipelined carry-save (3:2) reduction tree: NUM_PP pre-aligned WIDTH-bit rows in, one
//  sum/carry pair out with sum+carry == sum of rows (mod 2^WIDTH). Next-generation partial-product

---
 rtl/csa_tree_pipelined_if.sv | 28 ++
 rtl/csa_tree_pipelined.sv | 117 +++++++++++
 tb/tb_csa_tree_pipelined.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_tree_pipelined_if.sv
// Row/pair stream bundle for the carry-save reduction tree.
// Defining CSA_TREE_FINAL_ADD_EN adds the resolved out_result to the bundle.
interface csa_tree_pipelined_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_PP = 9
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_PP*WIDTH-1:0]   in_rows;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_sum;
  logic [WIDTH-1:0]          out_carry;
  logic                      busy;
`ifdef CSA_TREE_FINAL_ADD_EN
  logic [WIDTH-1:0]          out_result;

  modport master (output in_valid, in_rows, out_ready,
                  input  in_ready, out_valid, out_sum, out_carry, busy, out_result);
  modport slave  (input  in_valid, in_rows, out_ready,
                  output in_ready, out_valid, out_sum, out_carry, busy, out_result);
`else
  modport master (output in_valid, in_rows, out_ready,
                  input  in_ready, out_valid, out_sum, out_carry, busy);
  modport slave  (input  in_valid, in_rows, out_ready,
                  output in_ready, out_valid, out_sum, out_carry, busy);
`endif
endinterface

// File: rtl/csa_tree_pipelined.sv
// Pipelined 3:2 carry-save reduction tree: NUM_PP rows -> sum/carry pair, lock-step valid/ready.
// Optional CSA_TREE_FINAL_ADD_EN resolves the pair into out_result from the final-stage registers.
module csa_tree_pipelined #(
  parameter int WIDTH     = 32,
  parameter int NUM_PP    = 9,
  parameter int REG_EVERY = 2
) (
  input logic               clk,
  input logic               rst_n,
  csa_tree_pipelined_if.slave bus
);

  function automatic int rows_at(int n, int lv);
    int r;
    r = n;
    for (int i = 0; i < lv; i++) r = (r / 3) * 2 + (r % 3);
    return r;
  endfunction

  function automatic int num_levels(int n);
    int r;
    int l;
    r = n;
    l = 0;
    for (int i = 0; i < 64; i++) begin
      if (r > 2) begin
        r = (r / 3) * 2 + (r % 3);
        l++;
      end
    end
    return l;
  endfunction

  localparam int LEVELS  = num_levels(NUM_PP);
  localparam int LATENCY = (LEVELS == 0) ? 1 : (LEVELS + REG_EVERY - 1) / REG_EVERY;

  typedef logic [NUM_PP-1:0][WIDTH-1:0] rows_t;

  // w_comb[k]: rows produced by level k; w_row[k]: same rows after the optional register slice
  rows_t              w_comb [0:LEVELS];
  rows_t              w_row  [0:LEVELS];
  logic               w_adv;
  logic [LATENCY-1:0] r_vld;

  assign w_adv       = !r_vld[LATENCY-1] || bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[LATENCY-1];
  assign bus.busy      = |r_vld;

  // All stages move together; a stalled output freezes the whole pipe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= bus.in_valid;
      for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  generate
    for (genvar r = 0; r < NUM_PP; r++) begin : g_in
      assign w_comb[0][r] = bus.in_rows[r*WIDTH +: WIDTH];
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int NI = rows_at(NUM_PP, k-1);
      localparam int NG = NI / 3;
      localparam int NL = NI % 3;
      localparam int NO = 2 * NG + NL;

      for (genvar g = 0; g < NG; g++) begin : g_fa
        logic [WIDTH-1:0] w_a, w_b, w_c, w_maj;
        assign w_a   = w_row[k-1][3*g];
        assign w_b   = w_row[k-1][3*g+1];
        assign w_c   = w_row[k-1][3*g+2];
        assign w_maj = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
        assign w_comb[k][2*g]   = w_a ^ w_b ^ w_c;
        assign w_comb[k][2*g+1] = {w_maj[WIDTH-2:0], 1'b0};
      end

      for (genvar j = 0; j < NL; j++) begin : g_pass
        assign w_comb[k][2*NG+j] = w_row[k-1][3*NG+j];
      end

      for (genvar r = NO; r < NUM_PP; r++) begin : g_zero
        assign w_comb[k][r] = '0;
      end
    end

    for (genvar k = 0; k <= LEVELS; k++) begin : g_stg
      if (k == LEVELS) begin : g_fin
        // Only the last stage is reset so the pair reads zero out of reset
        logic [1:0][WIDTH-1:0] r_fin;
        always_ff @(posedge clk) begin
          if (!rst_n)     r_fin <= '0;
          else if (w_adv) r_fin <= w_comb[k][1:0];
        end
        assign w_row[k]      = w_comb[k];
        assign bus.out_sum   = r_fin[0];
        assign bus.out_carry = r_fin[1];
      end else if (k > 0 && (k % REG_EVERY) == 0) begin : g_reg
        rows_t r_stg;
        always_ff @(posedge clk) begin
          if (w_adv) r_stg <= w_comb[k];
        end
        assign w_row[k] = r_stg;
      end else begin : g_wire
        assign w_row[k] = w_comb[k];
      end
    end
  endgenerate

`ifdef CSA_TREE_FINAL_ADD_EN
  assign bus.out_result = bus.out_sum + bus.out_carry;
`endif

endmodule

// File: tb/tb_csa_tree_pipelined.sv
// Randomised and directed bench for csa_tree_pipelined against a row-sum scoreboard.
module tb_csa_tree_pipelined;
  localparam int W  = 32;
  localparam int N  = 9;
  localparam int RE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_tree_pipelined_if #(.WIDTH(W), .NUM_PP(N)) bus ();
  csa_tree_pipelined_if #(.WIDTH(W), .NUM_PP(2)) bus2 ();
  csa_tree_pipelined_if #(.WIDTH(W), .NUM_PP(3)) bus3 ();

  csa_tree_pipelined #(.WIDTH(W), .NUM_PP(N), .REG_EVERY(RE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  csa_tree_pipelined #(.WIDTH(W), .NUM_PP(2), .REG_EVERY(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  csa_tree_pipelined #(.WIDTH(W), .NUM_PP(3), .REG_EVERY(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  int errs = 0;
  int chks = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_sum(logic [N*W-1:0] rows);
    logic [31:0] s;
    s = '0;
    for (int r = 0; r < N; r++) s = s + rows[r*W +: W];
    return s;
  endfunction

  function automatic logic [N*W-1:0] rand_rows();
    logic [N*W-1:0] v;
    for (int r = 0; r < N; r++) begin
      case ($urandom_range(0, 7))
        0:       v[r*W +: W] = 32'h0;
        1:       v[r*W +: W] = 32'hFFFF_FFFF;
        2:       v[r*W +: W] = 32'h8000_0000;
        default: v[r*W +: W] = $urandom;
      endcase
    end
    return v;
  endfunction

  function automatic logic [N*W-1:0] id_rows(int id);
    logic [N*W-1:0] v;
    v[W-1:0] = id;
    for (int r = 1; r < N; r++) v[r*W +: W] = $urandom;
    return v;
  endfunction

  // Scoreboard: queue of expected row sums for accepted, not yet emitted items
  logic [31:0] q[$];
  int          n_out = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_s, prev_c;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_stall = 0;
    end else begin
      check("in_ready_rule", {31'b0, bus.in_ready}, {31'b0, (!bus.out_valid || bus.out_ready)});
      check("busy", {31'b0, bus.busy}, {31'b0, (q.size() != 0)});
      if (prev_stall) begin
        check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        check("stall_sum", bus.out_sum, prev_s);
        check("stall_carry", bus.out_carry, prev_c);
      end
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL spurious_out: out_valid=1 with no item in flight at %0t", $time);
        end else begin
          check("pair_sum", bus.out_sum + bus.out_carry, q[0]);
`ifdef CSA_TREE_FINAL_ADD_EN
          check("out_result", bus.out_result, q[0]);
`endif
          if (bus.out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(model_sum(bus.in_rows));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_s = bus.out_sum;
      prev_c = bus.out_carry;
    end
  end

  task automatic send_one(logic [N*W-1:0] rows, logic [31:0] exp, string name);
    @(posedge clk); #1;
    bus.in_rows   = rows;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({name, "_rdy"}, {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check({name, "_lat"}, {31'b0, bus.out_valid}, 32'd1);
    check({name, "_val"}, bus.out_sum + bus.out_carry, exp);
  endtask

  task automatic drain(string name);
    int k;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (bus.busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drained"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [N*W-1:0] rows;
    int c, id, base, acc_cnt;
    bit acc;

    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.in_rows = '0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1; bus2.in_rows = '0;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b1; bus3.in_rows = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_sum", bus.out_sum, 32'd0);
    check("rst_carry", bus.out_carry, 32'd0);

    // Shallow trees: single register stage
    @(posedge clk); #1;
    bus2.in_rows = {32'd7, 32'd5};
    bus3.in_rows = {32'd9, 32'd7, 32'd5};
    bus2.in_valid = 1'b1;
    bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
    @(negedge clk);
    check("pp2_valid", {31'b0, bus2.out_valid}, 32'd1);
    check("pp2_sum", bus2.out_sum, 32'd5);
    check("pp2_carry", bus2.out_carry, 32'd7);
    check("pp2_total", bus2.out_sum + bus2.out_carry, 32'd12);
    check("pp3_valid", {31'b0, bus3.out_valid}, 32'd1);
    check("pp3_sum", bus3.out_sum, 32'd11);
    check("pp3_carry", bus3.out_carry, 32'd10);
    check("pp3_total", bus3.out_sum + bus3.out_carry, 32'd21);

    for (int r = 0; r < N; r++) rows[r*W +: W] = 32'h1;
    send_one(rows, 32'h0000_0009, "t1_ones");
    for (int r = 0; r < N; r++) rows[r*W +: W] = 32'hFFFF_FFFF;
    send_one(rows, 32'hFFFF_FFF7, "t2_allf");
    rows = '0;
    rows[W-1:0] = 32'h8000_0000;
    send_one(rows, 32'h8000_0000, "t2_msb");
    drain("t2");

    // Streaming with a five-cycle downstream stall
    @(posedge clk); #1;
    c = 0; id = 1; base = n_out;
    while (id <= 20 && c < 300) begin
      bus.out_ready = !(c >= 5 && c <= 9);
      bus.in_rows   = id_rows(id);
      bus.in_valid  = 1'b1;
      @(negedge clk);
      if (c >= 5 && c <= 9) begin
        check("t3_stall_ovld", {31'b0, bus.out_valid}, 32'd1);
        check("t3_stall_rdy", {31'b0, bus.in_ready}, 32'd0);
      end
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) id++;
      c++;
    end
    check("t3_all_sent", id, 32'd21);
    drain("t3");
    check("t3_count", n_out - base, 32'd20);
    check("t3_queue_empty", q.size(), 32'd0);

    // Reset with two items in flight
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_rows = rand_rows();
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_rows = rand_rows();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t4_pre_busy", {31'b0, bus.busy}, 32'd1);
    check("t4_pre_valid", {31'b0, bus.out_valid}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_valid", {31'b0, bus.out_valid}, 32'd0);
    check("t4_busy", {31'b0, bus.busy}, 32'd0);
    check("t4_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("t4_sum", bus.out_sum, 32'd0);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    rows = rand_rows();
    send_one(rows, model_sum(rows), "t4_post");
    drain("t4");

    // Random traffic with random backpressure
    @(posedge clk); #1;
    acc_cnt = 0; c = 0; base = n_out;
    while (acc_cnt < 10000 && c < 60000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_rows   = rand_rows();
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) acc_cnt++;
      c++;
    end
    check("t6_accepted", acc_cnt, 32'd10000);
    drain("t6");
    check("t6_count", n_out - base, 32'd10000);
    check("t6_queue_empty", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
